// File: rtl/wmul_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : wmul_sequencer
// Brief    : Multi-cycle shift-add sequencer for the unsigned odd-subfield
//            wide-word multiply; all lanes advance in parallel.
// Revision : 1.0
// ============================================================================

`ifndef ALUWMULOU
`define ALUWMULOU 5'b01100
`endif
`ifndef W8
`define W8 2'b00
`endif
`ifndef W16
`define W16 2'b01
`endif

module wmul_sequencer #(
  parameter int RADIX_BITS = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [0:127] reg_A,
  input  logic [0:127] reg_B,
  input  logic [0:1]   ctrl_ww,
  input  logic [0:4]   alu_op,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [0:127] result,
  output logic         busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] C_LAST_BYTE = 4'(8 / RADIX_BITS - 1);
  localparam logic [3:0] C_LAST_HALF = 4'(16 / RADIX_BITS - 1);

  state_t       state_q, state_d;
  logic         half_q, half_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [0:127] acc_q, acc_d;
  logic [0:127] mc_q, mc_d;
  logic [0:63]  mp_q, mp_d;

  logic         w_is_byte, w_is_half;
  logic [0:127] w_load_mc_b, w_load_mc_h;
  logic [0:63]  w_load_mp_b, w_load_mp_h;
  logic [0:127] w_step_acc_b, w_step_acc_h;
  logic [0:127] w_step_mc_b, w_step_mc_h;
  logic [0:63]  w_step_mp_b, w_step_mp_h;
  logic         w_unused_bits;

  // Partial product for one radix digit: sum of the multiplicand shifted by each set digit bit.
  function automatic logic [31:0] f_pp(input logic [31:0] mc, input logic [3:0] dig);
    logic [31:0] s;
    s = '0;
    for (int j = 0; j < RADIX_BITS; j++) begin
      if (dig[j]) s = s + (mc << j);
    end
    return s;
  endfunction

  assign w_is_byte = (alu_op == `ALUWMULOU) && (ctrl_ww == (`W8 + 2'd1));
  assign w_is_half = (alu_op == `ALUWMULOU) && (ctrl_ww == (`W16 + 2'd1));

  // Bytes 0, 4, 8 and 12 are even subfields in both modes and never consumed.
  assign w_unused_bits = ^{reg_A[0:7], reg_A[32:39], reg_A[64:71], reg_A[96:103],
                           reg_B[0:7], reg_B[32:39], reg_B[64:71], reg_B[96:103]};

  // Multiplicands are kept zero-extended in result layout so they can shift into the upper half.
  for (genvar k = 0; k < 8; k++) begin : g_byte_lane
    logic [15:0] w_mc;
    logic [7:0]  w_mp;
    assign w_mc = mc_q[16*k +: 16];
    assign w_mp = mp_q[8*k +: 8];
    assign w_load_mc_b[16*k +: 16]  = {8'd0, reg_A[16*k+8 +: 8]};
    assign w_load_mp_b[8*k +: 8]    = reg_B[16*k+8 +: 8];
    assign w_step_acc_b[16*k +: 16] = acc_q[16*k +: 16] + 16'(f_pp({16'd0, w_mc}, w_mp[3:0]));
    assign w_step_mc_b[16*k +: 16]  = w_mc << RADIX_BITS;
    assign w_step_mp_b[8*k +: 8]    = w_mp >> RADIX_BITS;
  end

  for (genvar k = 0; k < 4; k++) begin : g_half_lane
    logic [31:0] w_mc;
    logic [15:0] w_mp;
    assign w_mc = mc_q[32*k +: 32];
    assign w_mp = mp_q[16*k +: 16];
    assign w_load_mc_h[32*k +: 32]  = {16'd0, reg_A[32*k+16 +: 16]};
    assign w_load_mp_h[16*k +: 16]  = reg_B[32*k+16 +: 16];
    assign w_step_acc_h[32*k +: 32] = acc_q[32*k +: 32] + f_pp(w_mc, w_mp[3:0]);
    assign w_step_mc_h[32*k +: 32]  = w_mc << RADIX_BITS;
    assign w_step_mp_h[16*k +: 16]  = w_mp >> RADIX_BITS;
  end

  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mc_d    = mc_q;
    mp_d    = mp_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          acc_d   = '0;
          cnt_d   = '0;
          half_d  = w_is_half;
          mc_d    = w_is_half ? w_load_mc_h : w_load_mc_b;
          mp_d    = w_is_half ? w_load_mp_h : w_load_mp_b;
          state_d = (w_is_byte || w_is_half) ? ST_MUL : ST_DONE;
        end
      end
      ST_MUL: begin
        acc_d = half_q ? w_step_acc_h : w_step_acc_b;
        mc_d  = half_q ? w_step_mc_h  : w_step_mc_b;
        mp_d  = half_q ? w_step_mp_h  : w_step_mp_b;
        // Counter stops at the last iteration rather than wrapping.
        if (cnt_q == (half_q ? C_LAST_HALF : C_LAST_BYTE)) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_DONE: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      half_q  <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      mc_q    <= '0;
      mp_q    <= '0;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mc_q    <= mc_d;
      mp_q    <= mp_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_DONE);
  assign busy       = (state_q != ST_IDLE);
  assign result     = acc_q;

endmodule

`default_nettype wire

// File: tb/tb_wmul_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_wmul_sequencer
// Brief    : Directed plus randomized bench for wmul_sequencer against a
//            cycle-level reference model built from lane products.
// Revision : 1.0
// ============================================================================

`ifndef ALUWMULOU
`define ALUWMULOU 5'b01100
`endif
`ifndef W8
`define W8 2'b00
`endif
`ifndef W16
`define W16 2'b01
`endif

module tb_wmul_sequencer;

  localparam int RADIX = 2;
  localparam int NB    = 8 / RADIX;
  localparam int NH    = 16 / RADIX;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic [0:127] reg_A;
  logic [0:127] reg_B;
  logic [0:1]   ctrl_ww;
  logic [0:4]   alu_op;
  logic         resp_valid;
  logic         resp_ready;
  logic [0:127] result;
  logic         busy;

  wmul_sequencer #(.RADIX_BITS(RADIX)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .reg_A(reg_A), .reg_B(reg_B), .ctrl_ww(ctrl_ww), .alu_op(alu_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // 0 = illegal, 1 = byte lanes, 2 = half lanes
  function automatic int f_mode(input logic [0:4] op, input logic [0:1] ww);
    if (op == `ALUWMULOU && ww == (`W8 + 2'd1))  return 1;
    if (op == `ALUWMULOU && ww == (`W16 + 2'd1)) return 2;
    return 0;
  endfunction

  function automatic logic [0:127] f_ref(input logic [0:127] a, input logic [0:127] b, input int md);
    logic [0:127] r;
    logic [15:0]  p16;
    logic [31:0]  p32;
    r = '0;
    if (md == 1) begin
      for (int k = 0; k < 8; k++) begin
        p16 = 16'(a[16*k+8 +: 8]) * 16'(b[16*k+8 +: 8]);
        r[16*k +: 16] = p16;
      end
    end else if (md == 2) begin
      for (int k = 0; k < 4; k++) begin
        p32 = 32'(a[32*k+16 +: 16]) * 32'(b[32*k+16 +: 16]);
        r[32*k +: 32] = p32;
      end
    end
    return r;
  endfunction

  // Reference: 0 idle, 1 computing (result not observable), 2 response pending.
  int           m_phase = 0;
  int           m_wait  = 0;
  logic [0:127] m_prod   = '0;
  logic [0:127] m_result = '0;

  always @(posedge clk) begin
    int md;
    if (reset) begin
      m_phase  = 0;
      m_result = '0;
    end else begin
      case (m_phase)
        0: if (req_valid) begin
             md       = f_mode(alu_op, ctrl_ww);
             m_prod   = f_ref(reg_A, reg_B, md);
             m_result = '0;
             if (md == 0) m_phase = 2;
             else begin
               m_phase = 1;
               m_wait  = (md == 1) ? NB : NH;
             end
           end
        1: begin
             m_wait--;
             if (m_wait == 0) begin
               m_phase  = 2;
               m_result = m_prod;
             end
           end
        default: if (resp_ready) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", req_ready, m_phase == 0);
      chk("resp_valid", resp_valid, m_phase == 2);
      chk("busy", busy, m_phase != 0);
      if (m_phase != 1) chk("result", result, m_result);
    end
  end

  function automatic logic [0:127] mk_b(input logic [7:0] odd);
    logic [0:127] w;
    for (int k = 0; k < 8; k++) w[16*k +: 16] = {8'($urandom), odd};
    return w;
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    while (m_phase != 0 && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    if (m_phase != 0) chk("idle_timeout", 1, 0);
  endtask

  task automatic do_req(input logic [0:127] a, input logic [0:127] b, input logic [0:4] op,
                        input logic [0:1] ww, input int exp_lat, input logic [0:127] exp_res,
                        input string name);
    int lat;
    bit seen;
    wait_idle();
    reg_A = a; reg_B = b; alu_op = op; ctrl_ww = ww; req_valid = 1'b1;
    @(posedge clk); #2;
    req_valid = 1'b0; reg_A = ~a; reg_B = ~b;
    lat = 0; seen = 1'b0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(negedge clk);
      if (resp_valid) begin seen = 1'b1; lat = i; end
    end
    chk({name, "_latency"}, lat, exp_lat);
    if (seen) chk({name, "_result"}, result, exp_res);
    @(posedge clk); #2;
  endtask

  initial begin
    logic [0:127] a, b;
    int r;
    reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b1;
    reg_A = '0; reg_B = '0; ctrl_ww = '0; alu_op = '0;
    @(posedge clk); @(posedge clk); #2;
    reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_result", result, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_resp_valid", resp_valid, 0);
    @(posedge clk); #2;

    // Byte lanes, all-ones operands.
    do_req(mk_b(8'hFF), mk_b(8'hFF), `ALUWMULOU, `W8 + 2'd1, NB + 1, {8{16'hFE01}}, "byte_ff");
    // Half lanes, lane 0 only.
    a = '0; b = '0;
    a[0:31] = 32'hABCD1234; b[0:31] = 32'h55550010;
    do_req(a, b, `ALUWMULOU, `W16 + 2'd1, 9, {32'h00012340, 96'd0}, "half_lane0");
    // Illegal opcode.
    do_req(mk_b(8'h12), mk_b(8'h34), `ALUWMULOU ^ 5'd1, `W8 + 2'd1, 1, 128'd0, "illegal_op");
    do_req(mk_b(8'h12), mk_b(8'h34), `ALUWMULOU, 2'd3, 1, 128'd0, "illegal_ww");

    // Backpressure held in the response state.
    resp_ready = 1'b0;
    wait_idle();
    reg_A = mk_b(8'h03); reg_B = mk_b(8'h03); alu_op = `ALUWMULOU; ctrl_ww = `W8 + 2'd1;
    req_valid = 1'b1;
    @(posedge clk); #2;
    req_valid = 1'b0;
    repeat (NB) begin @(posedge clk); #2; end
    for (int i = 0; i < 5; i++) begin
      req_valid = ~req_valid; reg_A = mk_b(8'($urandom)); reg_B = mk_b(8'($urandom));
      @(negedge clk);
      chk("bp_resp_valid", resp_valid, 1);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_result", result, {8{16'h0009}});
      @(posedge clk); #2;
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    @(posedge clk); #2;

    // Reset during the third computing cycle.
    wait_idle();
    reg_A = mk_b(8'h77); reg_B = mk_b(8'h55); alu_op = `ALUWMULOU; ctrl_ww = `W8 + 2'd1;
    req_valid = 1'b1;
    @(posedge clk); #2;
    req_valid = 1'b0;
    @(posedge clk); #2;
    @(posedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_result", result, 0);
    chk("midrst_req_ready", req_ready, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("midrst_no_resp", resp_valid, 0);
    end
    @(posedge clk); #2;
    do_req(mk_b(8'h0F), mk_b(8'h11), `ALUWMULOU, `W8 + 2'd1, NB + 1, {8{16'h00FF}}, "after_rst");

    // Back-to-back with the consumer always ready.
    wait_idle();
    reg_A = mk_b(8'h0F); reg_B = mk_b(8'h11); alu_op = `ALUWMULOU; ctrl_ww = `W8 + 2'd1;
    req_valid = 1'b1;
    @(posedge clk); #2;
    reg_A = mk_b(8'hFF); reg_B = mk_b(8'h02);
    for (int c = 1; c <= 2 * NB + 3; c++) begin
      @(negedge clk);
      if (c == NB + 1) begin
        chk("b2b_first_valid", resp_valid, 1);
        chk("b2b_first_result", result, {8{16'h00FF}});
      end
      if (c == NB + 2) chk("b2b_second_accept", req_ready, 1);
      if (c == NB + 3) req_valid = 1'b0;
      if (c == 2 * NB + 3) begin
        chk("b2b_second_valid", resp_valid, 1);
        chk("b2b_second_result", result, {8{16'h01FE}});
      end
    end
    @(posedge clk); #2;

    // Randomized traffic, including requests and input churn while busy.
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 149) == 0);
      req_valid  = ($urandom_range(0, 2) != 0);
      resp_ready = ($urandom_range(0, 2) != 0);
      for (int k = 0; k < 4; k++) begin
        a[32*k +: 32] = $urandom;
        b[32*k +: 32] = $urandom;
      end
      reg_A = a; reg_B = b;
      r = $urandom_range(0, 7);
      if (r <= 2) begin
        alu_op = `ALUWMULOU; ctrl_ww = `W8 + 2'd1;
      end else if (r <= 5) begin
        alu_op = `ALUWMULOU; ctrl_ww = `W16 + 2'd1;
      end else if (r == 6) begin
        alu_op = `ALUWMULOU ^ 5'($urandom_range(1, 31)); ctrl_ww = 2'($urandom);
      end else begin
        alu_op = `ALUWMULOU; ctrl_ww = ($urandom_range(0, 1) != 0) ? 2'd0 : 2'd3;
      end
      @(posedge clk); #2;
    end
    reset = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
    wait_idle();
    repeat (3) @(posedge clk);
    #2;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
